// File: rtl/candy_alu_seq.sv
// Sequencer that queues ALU requests, drives them one at a time into candy_alu and returns tagged results.
// Optional macro CANDY_ALU_SEQ_FLAGS_EN adds registered zero/negative result flags.
//
// state   | meaning
// IDLE    | nothing in flight, waiting for a queued request
// ISSUE   | head request on ALU operands, popped from the FIFO
// WAIT    | operands held while the ALU pipeline settles
// RESP    | result presented until the consumer takes it
module candy_alu_seq #(
  parameter int ALU_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_op_i,
  input  logic [23:0] req_a_i,
  input  logic [23:0] req_b_i,
  input  logic [2:0]  req_tag_i,
  output logic [7:0]  aluop_o,
  output logic [23:0] reg1_o,
  output logic [23:0] reg2_o,
  input  logic [23:0] alu_res_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [23:0] rsp_res_o,
  output logic [2:0]  rsp_tag_o
`ifdef CANDY_ALU_SEQ_FLAGS_EN
  ,
  output logic        rsp_zero_o,
  output logic        rsp_neg_o
`endif
);

  localparam logic [7:0] EXE_NOP = 8'h00;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = 3;
  localparam int ENT_W = 8 + 24 + 24 + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [7:0]         aluop_q, aluop_d;
  logic [23:0]        reg1_q, reg1_d;
  logic [23:0]        reg2_q, reg2_d;
  logic [2:0]         tag_q, tag_d;
  logic [23:0]        rsp_res_q, rsp_res_d;
  logic [2:0]         rsp_tag_q, rsp_tag_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic               push;
  logic               pop;
  logic               capture;
  logic               fifo_nonempty;
  logic [7:0]         head_op;
  logic [23:0]        head_a;
  logic [23:0]        head_b;
  logic [2:0]         head_tag;

  assign req_ready_o   = (count_q != CNT_W'(DEPTH));
  assign push          = req_valid_i && req_ready_o;
  assign fifo_nonempty = (count_q != '0);
  assign {head_op, head_a, head_b, head_tag} = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_op_i, req_a_i, req_b_i, req_tag_i};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Operand registers load on entry to ISSUE so the head is on the bus for the whole ISSUE cycle.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    aluop_d   = aluop_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    tag_d     = tag_q;
    rsp_res_d = rsp_res_q;
    rsp_tag_d = rsp_tag_q;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          state_d = S_ISSUE;
          aluop_d = head_op;
          reg1_d  = head_a;
          reg2_d  = head_b;
          tag_d   = head_tag;
        end
      end
      S_ISSUE: begin
        pop       = 1'b1;
        lat_cnt_d = LAT_W'(ALU_LAT - 1);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          capture   = 1'b1;
          rsp_res_d = alu_res_i;
          rsp_tag_d = tag_q;
          aluop_d   = EXE_NOP;
          reg1_d    = '0;
          reg2_d    = '0;
          state_d   = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          if (fifo_nonempty) begin
            state_d = S_ISSUE;
            aluop_d = head_op;
            reg1_d  = head_a;
            reg2_d  = head_b;
            tag_d   = head_tag;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      lat_cnt_q <= '0;
      aluop_q   <= EXE_NOP;
      reg1_q    <= '0;
      reg2_q    <= '0;
      tag_q     <= '0;
      rsp_res_q <= '0;
      rsp_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      lat_cnt_q <= lat_cnt_d;
      aluop_q   <= aluop_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      tag_q     <= tag_d;
      rsp_res_q <= rsp_res_d;
      rsp_tag_q <= rsp_tag_d;
    end
  end

  assign aluop_o     = aluop_q;
  assign reg1_o      = reg1_q;
  assign reg2_o      = reg2_q;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_res_o   = rsp_res_q;
  assign rsp_tag_o   = rsp_tag_q;

`ifdef CANDY_ALU_SEQ_FLAGS_EN
  logic rsp_zero_q, rsp_zero_d;
  logic rsp_neg_q, rsp_neg_d;

  always_comb begin
    rsp_zero_d = rsp_zero_q;
    rsp_neg_d  = rsp_neg_q;
    if (capture) begin
      rsp_zero_d = (alu_res_i == '0);
      rsp_neg_d  = alu_res_i[23];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_zero_q <= 1'b0;
      rsp_neg_q  <= 1'b0;
    end else begin
      rsp_zero_q <= rsp_zero_d;
      rsp_neg_q  <= rsp_neg_d;
    end
  end

  assign rsp_zero_o = rsp_zero_q;
  assign rsp_neg_o  = rsp_neg_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule
